// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: diff = a - b over WIDTH cycles, LSB first.
// One full-subtractor cell and a registered borrow. Results stay on registered
// outputs until the next operation completes.
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-2:0] sr_q;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q;
  logic             b_msb_q;

  logic             bit_d;
  logic             brw_d;
  logic [WIDTH-1:0] sr_d;

  // Full-subtractor cell on the current LSBs; sr_d is the result shifted by one bit.
  always_comb begin
    bit_d = sa_q[0] ^ sb_q[0] ^ brw_q;
    brw_d = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);
    sr_d  = {bit_d, sr_q};
  end

  // Control FSM and serial datapath; outputs update only on completion or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sa_q       <= '0;
      sb_q       <= '0;
      sr_q       <= '0;
      brw_q      <= 1'b0;
      cnt_q      <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            busy    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          sr_q  <= sr_d[WIDTH-1:1];
          brw_q <= brw_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            diff       <= sr_d;
            borrow_out <= brw_d;
            overflow   <= (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
            done       <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
